cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Shares the board's 17-bit local CPU register bus between two internal masters: the host command bridge (requester 0) and the init/poll sequencer (requester 1). It grants the bus round-robin and generates each bus cycle with fixed, parameterised timing on CpuCs_n/CpuWr_n/CpuRd_n/CpuAddr/CpuData_out. For reads, it captures CpuData_in and returns it to the granted requester with a one-cycle acknowledge. It sits directly in front of the CPU interface decoder, in the CpuClk domain.

## Interface
- STROBE_CYC, 2: cycles Wr_n/Rd_n held low per access; legal 1..15.
- CpuClk  in  1  bus clock; all logic on rising edge.
- RstCpu  in  1  asynchronous, active-high reset.
- Req0_Valid / Req1_Valid  in  1  request pending; held high until the matching Ack.
- Req0_Wr / Req1_Wr  in  1  1 = write, 0 = read; sampled at grant.
- Req0_Addr / Req1_Addr  in  17  register address; sampled at grant.
- Req0_WrData / Req1_WrData  in  16  write data; sampled at grant.
- Req0_Ack / Req1_Ack  out  1  one-cycle completion pulse.
- Req0_RdData / Req1_RdData  out  16  read data; valid with Ack, held until that requester's next read Ack.
- CpuCs_n  out  1  bus chip select, active low.
- CpuWr_n  out  1  write strobe, active low.
- CpuRd_n  out  1  read strobe, active low.
- CpuAddr  out  17  bus address.
- CpuData_out  out  16  bus write data.
- CpuData_in  in  16  bus read data, registered by the slave, valid one cycle after Cs_n falls with stable address.
- Busy  out  1  high from SETUP through ACK.
- GrantId  out  1  requester owning the current or last transaction.

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - SETUP: Cs_n=0, strobes high; 1 cycle.
  - STROBE: Cs_n=0, Wr_n or Rd_n=0; STROBE_CYC cycles.
  - HOLD: Cs_n=0, strobes high; 1 cycle.
  - ACK: Cs_n=1; 1 cycle, then IDLE.
- Arbitration happens only in IDLE.
  - A single valid request is granted.
  - If both are valid, grant the requester that is not LastGrant.
  - LastGrant resets to 1, so requester 0 wins the first tie.
- At grant, register Wr, Addr and WrData into CpuAddr/CpuData_out and an internal direction bit, update LastGrant/GrantId, and enter SETUP.
- CpuAddr and CpuData_out are stable from SETUP through HOLD. They keep their last value in IDLE/ACK; they are not cleared.
- STROBE counter: 4-bit, loaded with STROBE_CYC-1 on entering STROBE, decrements each cycle, exits at 0.
- Reads: CpuData_in is captured on the clock edge that leaves the last STROBE cycle. It is copied to ReqN_RdData in ACK.
- Writes: RdData is unchanged.
- ACK state: pulse ReqN_Ack for the granted N only.
- Requester dropping Valid mid-transaction: the access completes and Ack still pulses. The requester must ignore it.
- A requester still asserting Valid in the cycle after Ack is treated as a new request. It competes normally at the next IDLE.
- Asynchronous reset, any state:
  - immediately CpuCs_n=CpuWr_n=CpuRd_n=1, CpuAddr=0, CpuData_out=0;
  - Acks=0, RdData=0, Busy=0, GrantId=0, LastGrant=1, FSM=IDLE.
  - An in-flight access is dropped with no Ack.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Valid seen high at IDLE edge T:
  - SETUP at T+1;
  - STROBE at T+2..T+1+STROBE_CYC;
  - HOLD at T+2+STROBE_CYC;
  - Ack at T+3+STROBE_CYC (T+5 for the default).
- Transaction occupancy is STROBE_CYC+4 cycles including IDLE. Back-to-back throughput is one access per 6 cycles (default).
- Cs_n is high for at least 2 cycles (ACK+IDLE) between accesses.
- Wr_n and Rd_n never fall in the same cycle as Cs_n and never are low together.

## Test plan
- Write: Req0 write 0x0000B data 0x0001 -> Cs_n low T+1..T+4, Wr_n low T+2..T+3, CpuAddr=0x0000B, CpuData_out=0x0001, Req0_Ack at T+5, Rd_n never low.
- Read: Req1 read 0x04000 with CpuData_in=0x1971 -> Rd_n low two cycles, Req1_RdData=0x1971 with Req1_Ack at T+5, Req0_RdData unchanged.
- Contention: both Valid held for 4 accesses -> grant order 0,1,0,1; each Ack exactly once per access; GrantId tracks grants.
- Single requester streaming: Req0 Valid held for 3 accesses, Req1 idle -> three consecutive grants to 0, 6-cycle spacing, Cs_n high ≥2 cycles between.
- Reset in STROBE: assert RstCpu mid-strobe -> same-cycle Cs_n/Wr_n/Rd_n=1, no Ack. After release, a fresh tie is granted to requester 0.
- STROBE_CYC=1: read -> Rd_n low one cycle, Ack at T+4, data captured correctly.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// Requester handshakes and CPU register bus pins shared by the arbiter and its peers.
// The arbiter connects through the slave modport; the requesters and bus model connect through master.
interface cpu_bus_arbiter_if;
    logic        Req0_Valid;
    logic        Req0_Wr;
    logic [16:0] Req0_Addr;
    logic [15:0] Req0_WrData;
    logic        Req0_Ack;
    logic [15:0] Req0_RdData;

    logic        Req1_Valid;
    logic        Req1_Wr;
    logic [16:0] Req1_Addr;
    logic [15:0] Req1_WrData;
    logic        Req1_Ack;
    logic [15:0] Req1_RdData;

    logic        CpuCs_n;
    logic        CpuWr_n;
    logic        CpuRd_n;
    logic [16:0] CpuAddr;
    logic [15:0] CpuData_out;
    logic [15:0] CpuData_in;

    logic        Busy;
    logic        GrantId;

    modport master (
        output Req0_Valid, Req0_Wr, Req0_Addr, Req0_WrData,
        input  Req0_Ack, Req0_RdData,
        output Req1_Valid, Req1_Wr, Req1_Addr, Req1_WrData,
        input  Req1_Ack, Req1_RdData,
        input  CpuCs_n, CpuWr_n, CpuRd_n, CpuAddr, CpuData_out,
        output CpuData_in,
        input  Busy, GrantId
    );

    modport slave (
        input  Req0_Valid, Req0_Wr, Req0_Addr, Req0_WrData,
        output Req0_Ack, Req0_RdData,
        input  Req1_Valid, Req1_Wr, Req1_Addr, Req1_WrData,
        output Req1_Ack, Req1_RdData,
        output CpuCs_n, CpuWr_n, CpuRd_n, CpuAddr, CpuData_out,
        input  CpuData_in,
        output Busy, GrantId
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter for two masters of the 17-bit CPU register bus, generating
// fixed-timing SETUP/STROBE/HOLD/ACK cycles with fully registered outputs.
module cpu_bus_arbiter #(
    parameter int unsigned STROBE_CYC = 2
) (
    input  logic              CpuClk,
    input  logic              RstCpu,
    cpu_bus_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    state_t      state;
    logic [3:0]  strobeCnt;
    logic        isWr;
    logic        lastGrant;
    logic [15:0] rdCapture;
    logic        grantSel;

    // Tie goes to whoever did not win last; a lone request always wins.
    always_comb begin
        grantSel = bus.Req1_Valid;
        if (bus.Req0_Valid && bus.Req1_Valid)
            grantSel = ~lastGrant;
    end

    always_ff @(posedge CpuClk or posedge RstCpu) begin
        if (RstCpu) begin
            state           <= IDLE;
            strobeCnt       <= '0;
            isWr            <= 1'b0;
            lastGrant       <= 1'b1;
            rdCapture       <= '0;
            bus.CpuCs_n     <= 1'b1;
            bus.CpuWr_n     <= 1'b1;
            bus.CpuRd_n     <= 1'b1;
            bus.CpuAddr     <= '0;
            bus.CpuData_out <= '0;
            bus.Req0_Ack    <= 1'b0;
            bus.Req1_Ack    <= 1'b0;
            bus.Req0_RdData <= '0;
            bus.Req1_RdData <= '0;
            bus.Busy        <= 1'b0;
            bus.GrantId     <= 1'b0;
        end else begin
            bus.Req0_Ack <= 1'b0;
            bus.Req1_Ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req0_Valid || bus.Req1_Valid) begin
                        state       <= SETUP;
                        bus.CpuCs_n <= 1'b0;
                        bus.Busy    <= 1'b1;
                        bus.GrantId <= grantSel;
                        lastGrant   <= grantSel;
                        if (grantSel) begin
                            isWr            <= bus.Req1_Wr;
                            bus.CpuAddr     <= bus.Req1_Addr;
                            bus.CpuData_out <= bus.Req1_WrData;
                        end else begin
                            isWr            <= bus.Req0_Wr;
                            bus.CpuAddr     <= bus.Req0_Addr;
                            bus.CpuData_out <= bus.Req0_WrData;
                        end
                    end
                end
                SETUP: begin
                    state     <= STROBE;
                    strobeCnt <= CNT_LOAD;
                    if (isWr)
                        bus.CpuWr_n <= 1'b0;
                    else
                        bus.CpuRd_n <= 1'b0;
                end
                STROBE: begin
                    if (strobeCnt == 4'd0) begin
                        state       <= HOLD;
                        bus.CpuWr_n <= 1'b1;
                        bus.CpuRd_n <= 1'b1;
                        if (!isWr)
                            rdCapture <= bus.CpuData_in;
                    end else begin
                        strobeCnt <= strobeCnt - 4'd1;
                    end
                end
                HOLD: begin
                    state       <= ACK;
                    bus.CpuCs_n <= 1'b1;
                    // Read data lands in the same cycle as the Ack pulse.
                    if (bus.GrantId) begin
                        bus.Req1_Ack <= 1'b1;
                        if (!isWr)
                            bus.Req1_RdData <= rdCapture;
                    end else begin
                        bus.Req0_Ack <= 1'b1;
                        if (!isWr)
                            bus.Req0_RdData <= rdCapture;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: directed accesses push expectations, a negedge
// monitor pops them on every Ack and checks timing, bus values and read data.
module tb_cpu_bus_arbiter;

    localparam int S_A = 2;
    localparam int S_B = 1;

    logic CpuClk = 1'b0;
    logic RstCpu;
    always #5 CpuClk = ~CpuClk;

    cpu_bus_arbiter_if ifA ();
    cpu_bus_arbiter_if ifB ();

    cpu_bus_arbiter #(.STROBE_CYC(S_A)) dutA (.CpuClk(CpuClk), .RstCpu(RstCpu), .bus(ifA));
    cpu_bus_arbiter #(.STROBE_CYC(S_B)) dutB (.CpuClk(CpuClk), .RstCpu(RstCpu), .bus(ifB));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CpuClk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", nm, act, req, cyc);
        end
    endtask

    // Registered slave: drives read data one cycle after it sees chip select low.
    function automatic logic [15:0] slaveData(input logic [16:0] a);
        if (a == 17'h04000) return 16'h1971;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(posedge CpuClk) begin
        ifA.CpuData_in <= !ifA.CpuCs_n ? slaveData(ifA.CpuAddr) : 16'hDEAD;
        ifB.CpuData_in <= !ifB.CpuCs_n ? slaveData(ifB.CpuAddr) : 16'hDEAD;
    end

    typedef struct {
        bit          id;
        bit          wr;
        logic [16:0] addr;
        logic [15:0] data;
        int          ackCyc;
    } exp_t;

    exp_t sb[$];

    int          csLow, wrLow, rdLow, csHigh;
    bit          seenCs;
    logic        prevCs;
    logic [15:0] rdModel [2];
    exp_t        e;

    always @(negedge CpuClk) begin
        if (RstCpu) begin
            sb.delete();
            rdModel[0] = '0;
            rdModel[1] = '0;
            csLow = 0; wrLow = 0; rdLow = 0; csHigh = 0;
            seenCs = 1'b0;
            prevCs = 1'b1;
        end else begin
            if (!ifA.CpuCs_n) begin
                if (prevCs) begin
                    if (seenCs) check("cs_gap", 32'(csHigh >= 2), 1);
                    check("busy_setup", ifA.Busy, 1'b1);
                    if (sb.size() != 0) check("grant_setup", ifA.GrantId, sb[0].id);
                    seenCs = 1'b1;
                end
                csLow++;
                csHigh = 0;
            end else begin
                csHigh++;
            end
            if (!ifA.CpuWr_n || !ifA.CpuRd_n) begin
                check("strobe_excl", ifA.CpuWr_n | ifA.CpuRd_n, 1'b1);
                check("strobe_after_cs", prevCs, 1'b0);
            end
            if (!ifA.CpuWr_n) wrLow++;
            if (!ifA.CpuRd_n) rdLow++;

            if (ifA.Req0_Ack || ifA.Req1_Ack) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none at cyc %0d",
                             ifA.Req0_Ack, ifA.Req1_Ack, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_single", ifA.Req0_Ack & ifA.Req1_Ack, 1'b0);
                    check("ack_id", ifA.Req1_Ack, e.id);
                    check("ack_cyc", cyc, e.ackCyc);
                    check("grant_id", ifA.GrantId, e.id);
                    check("busy_ack", ifA.Busy, 1'b1);
                    check("bus_addr", ifA.CpuAddr, e.addr);
                    if (e.wr) check("bus_wdata", ifA.CpuData_out, e.data);
                    check("wr_cycles", wrLow, e.wr ? S_A : 0);
                    check("rd_cycles", rdLow, e.wr ? 0 : S_A);
                    check("cs_cycles", csLow, S_A + 2);
                    if (!e.wr) rdModel[e.id] = e.data;
                    check("rddata0", ifA.Req0_RdData, rdModel[0]);
                    check("rddata1", ifA.Req1_RdData, rdModel[1]);
                end
                csLow = 0; wrLow = 0; rdLow = 0;
            end
            prevCs = ifA.CpuCs_n;
        end
    end

    // Keeps each requester's Valid high until it has collected its quota of Acks.
    task automatic runA(input int want0, input int want1, input string nm);
        int n0 = 0;
        int n1 = 0;
        for (int k = 0; k < 120 && !(n0 == want0 && n1 == want1); k++) begin
            @(negedge CpuClk);
            if (ifA.Req0_Ack) begin n0++; if (n0 == want0) ifA.Req0_Valid = 1'b0; end
            if (ifA.Req1_Ack) begin n1++; if (n1 == want1) ifA.Req1_Valid = 1'b0; end
        end
        ifA.Req0_Valid = 1'b0;
        ifA.Req1_Valid = 1'b0;
        check({nm, "_acks0"}, n0, want0);
        check({nm, "_acks1"}, n1, want1);
        repeat (3) @(negedge CpuClk);
        check({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic setReq(input bit id, input bit wr, input logic [16:0] a, input logic [15:0] d);
        if (id) begin
            ifA.Req1_Wr = wr; ifA.Req1_Addr = a; ifA.Req1_WrData = d; ifA.Req1_Valid = 1'b1;
        end else begin
            ifA.Req0_Wr = wr; ifA.Req0_Addr = a; ifA.Req0_WrData = d; ifA.Req0_Valid = 1'b1;
        end
    endtask

    int  c;
    int  rdLowB;
    int  ackCycB;
    bit  wrSeenB;
    bit  strobeSeen;

    initial begin
        RstCpu = 1'b1;
        ifA.Req0_Valid = 1'b0; ifA.Req0_Wr = 1'b0; ifA.Req0_Addr = '0; ifA.Req0_WrData = '0;
        ifA.Req1_Valid = 1'b0; ifA.Req1_Wr = 1'b0; ifA.Req1_Addr = '0; ifA.Req1_WrData = '0;
        ifB.Req0_Valid = 1'b0; ifB.Req0_Wr = 1'b0; ifB.Req0_Addr = '0; ifB.Req0_WrData = '0;
        ifB.Req1_Valid = 1'b0; ifB.Req1_Wr = 1'b0; ifB.Req1_Addr = '0; ifB.Req1_WrData = '0;
        repeat (3) @(negedge CpuClk);

        check("rst_cs",    ifA.CpuCs_n, 1'b1);
        check("rst_wr",    ifA.CpuWr_n, 1'b1);
        check("rst_rd",    ifA.CpuRd_n, 1'b1);
        check("rst_addr",  ifA.CpuAddr, 17'h0);
        check("rst_dout",  ifA.CpuData_out, 16'h0);
        check("rst_busy",  ifA.Busy, 1'b0);
        check("rst_grant", ifA.GrantId, 1'b0);
        check("rst_acks",  {ifA.Req0_Ack, ifA.Req1_Ack}, 2'b00);
        check("rst_rdd",   {ifA.Req0_RdData, ifA.Req1_RdData}, 32'h0);
        RstCpu = 1'b0;
        repeat (2) @(negedge CpuClk);

        // Single write from requester 0.
        c = cyc;
        setReq(1'b0, 1'b1, 17'h0000B, 16'h0001);
        sb.push_back('{1'b0, 1'b1, 17'h0000B, 16'h0001, c + 5});
        runA(1, 0, "write");

        // Single read from requester 1; requester 0's read data stays 0.
        c = cyc;
        setReq(1'b1, 1'b0, 17'h04000, 16'h0000);
        sb.push_back('{1'b1, 1'b0, 17'h04000, 16'h1971, c + 5});
        runA(0, 1, "read");

        // Contention: both held, requester 0 writes, requester 1 reads.
        c = cyc;
        setReq(1'b0, 1'b1, 17'h00100, 16'hAAAA);
        setReq(1'b1, 1'b0, 17'h00200, 16'h0000);
        sb.push_back('{1'b0, 1'b1, 17'h00100, 16'hAAAA, c + 5});
        sb.push_back('{1'b1, 1'b0, 17'h00200, 16'h585A, c + 11});
        sb.push_back('{1'b0, 1'b1, 17'h00100, 16'hAAAA, c + 17});
        sb.push_back('{1'b1, 1'b0, 17'h00200, 16'h585A, c + 23});
        runA(2, 2, "contend");

        // Requester 0 streams three reads back to back.
        c = cyc;
        setReq(1'b0, 1'b0, 17'h00123, 16'h0000);
        sb.push_back('{1'b0, 1'b0, 17'h00123, 16'h5B79, c + 5});
        sb.push_back('{1'b0, 1'b0, 17'h00123, 16'h5B79, c + 11});
        sb.push_back('{1'b0, 1'b0, 17'h00123, 16'h5B79, c + 17});
        runA(3, 0, "stream");

        // Reset while a write strobe is active.
        setReq(1'b0, 1'b1, 17'h1FFFF, 16'hBEEF);
        sb.push_back('{1'b0, 1'b1, 17'h1FFFF, 16'hBEEF, cyc + 5});
        strobeSeen = 1'b0;
        for (int k = 0; k < 10 && !strobeSeen; k++) begin
            @(negedge CpuClk);
            strobeSeen = !ifA.CpuWr_n;
        end
        check("rst_reach_strobe", strobeSeen, 1'b1);
        #2 RstCpu = 1'b1;
        #1;
        check("arst_cs",    ifA.CpuCs_n, 1'b1);
        check("arst_wr",    ifA.CpuWr_n, 1'b1);
        check("arst_rd",    ifA.CpuRd_n, 1'b1);
        check("arst_addr",  ifA.CpuAddr, 17'h0);
        check("arst_dout",  ifA.CpuData_out, 16'h0);
        check("arst_busy",  ifA.Busy, 1'b0);
        check("arst_grant", ifA.GrantId, 1'b0);
        check("arst_rdd",   {ifA.Req0_RdData, ifA.Req1_RdData}, 32'h0);
        ifA.Req0_Valid = 1'b0;
        repeat (2) begin
            @(negedge CpuClk);
            check("arst_noack", {ifA.Req0_Ack, ifA.Req1_Ack}, 2'b00);
        end
        RstCpu = 1'b0;
        c = cyc;
        setReq(1'b0, 1'b1, 17'h000AA, 16'h1234);
        setReq(1'b1, 1'b1, 17'h000BB, 16'h4321);
        sb.push_back('{1'b0, 1'b1, 17'h000AA, 16'h1234, c + 5});
        sb.push_back('{1'b1, 1'b1, 17'h000BB, 16'h4321, c + 11});
        runA(1, 1, "post_rst");

        // Single-cycle strobe instance: read from requester 0.
        @(negedge CpuClk);
        c = cyc;
        ifB.Req0_Wr = 1'b0; ifB.Req0_Addr = 17'h04000; ifB.Req0_Valid = 1'b1;
        rdLowB = 0; ackCycB = -1; wrSeenB = 1'b0;
        for (int k = 0; k < 20 && ackCycB < 0; k++) begin
            @(negedge CpuClk);
            if (!ifB.CpuRd_n) rdLowB++;
            if (!ifB.CpuWr_n) wrSeenB = 1'b1;
            if (ifB.Req0_Ack) begin
                ackCycB = cyc;
                ifB.Req0_Valid = 1'b0;
                check("s1_rddata", ifB.Req0_RdData, 16'h1971);
            end
        end
        check("s1_ack_cyc", ackCycB, c + 4);
        check("s1_rd_cycles", rdLowB, 1);
        check("s1_no_wr", wrSeenB, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
